// File: rtl/reg_file_gen_pkg.sv
// Shared encodings for the generic register file and its register cell.
package reg_file_gen_pkg;

    // Per-cycle operation applied to every enabled register.
    typedef enum logic [1:0] {
        FS_DEC  = 2'd0,
        FS_INC  = 2'd1,
        FS_LOAD = 2'd2,
        FS_CLR  = 2'd3
    } funsel_e;

    // Destination half for a half-width load.
    typedef enum logic {
        HS_LOW  = 1'b0,
        HS_HIGH = 1'b1
    } halfsel_e;

endpackage

// File: rtl/reg_file_gen_gen_register.sv
// One counter/load register cell: decrement, increment, full/half load, clear,
// with a registered one-shot wrap/saturate event flag.
module gen_register
    import reg_file_gen_pkg::*;
#(
    parameter int unsigned    W         = 8,
    parameter bit             SAT       = 1'b0,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         En,
    input  logic [1:0]   FunSel,
    input  logic         HalfEn,
    input  logic         HalfSel,
    input  logic [W-1:0] I,
    output logic [W-1:0] Q,
    output logic         Ovf
);

    localparam int unsigned HW = W / 2;

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;

    // Next-state value and event flag; a disabled cell holds and drops Ovf.
    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (En) begin
            case (funsel_e'(FunSel))
                FS_DEC: begin
                    if (q_q == '0) begin
                        ovf_d = 1'b1;
                        if (!SAT) q_d = '1;
                    end else begin
                        q_d = q_q - W'(1);
                    end
                end
                FS_INC: begin
                    if (q_q == '1) begin
                        ovf_d = 1'b1;
                        if (!SAT) q_d = '0;
                    end else begin
                        q_d = q_q + W'(1);
                    end
                end
                FS_LOAD: begin
                    if (!HalfEn) begin
                        q_d = I;
                    end else if (halfsel_e'(HalfSel) == HS_HIGH) begin
                        q_d[W-1:HW] = I[HW-1:0];
                    end else begin
                        q_d[HW-1:0] = I[HW-1:0];
                    end
                end
                FS_CLR:  q_d = '0;
                default: q_d = q_q;
            endcase
        end
    end

    // State and flag registers with asynchronous reset.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            q_q   <= RESET_VAL;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_q;
    assign Ovf = ovf_q;

endmodule

// File: rtl/reg_file_gen.sv
// Parametrised register file: NREG identical register cells sharing one
// operation bus, two combinational read ports, per-register event flags.
module reg_file_gen
    import reg_file_gen_pkg::*;
#(
    parameter int unsigned     W         = 8,
    parameter int unsigned     NREG      = 4,
    parameter bit              SAT       = 1'b0,
    parameter logic [W-1:0]    RESET_VAL = '0,
    localparam int unsigned    SW        = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [NREG-1:0] RegSel,
    input  logic [1:0]      FunSel,
    input  logic            HalfEn,
    input  logic            HalfSel,
    input  logic [W-1:0]    I,
    input  logic [SW-1:0]   OutASel,
    input  logic [SW-1:0]   OutBSel,
    output logic [W-1:0]    OutA,
    output logic [W-1:0]    OutB,
    output logic [NREG-1:0] Ovf
);

    if (W < 2 || (W % 2) != 0) begin : g_bad_w
        $error("reg_file_gen: W must be even and at least 2");
    end
    if (NREG < 1 || NREG > 16) begin : g_bad_nreg
        $error("reg_file_gen: NREG must be in 1..16");
    end

    logic [W-1:0] q [NREG];

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        gen_register #(
            .W         (W),
            .SAT       (SAT),
            .RESET_VAL (RESET_VAL)
        ) u_reg (
            .Clock   (Clock),
            .Reset_n (Reset_n),
            .En      (~RegSel[k]),
            .FunSel  (FunSel),
            .HalfEn  (HalfEn),
            .HalfSel (HalfSel),
            .I       (I),
            .Q       (q[k]),
            .Ovf     (Ovf[k])
        );
    end

    // Read multiplexers; selects with no matching register yield zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (OutASel == SW'(k)) OutA = q[k];
            if (OutBSel == SW'(k)) OutB = q[k];
        end
    end

endmodule

// File: tb/tb_reg_file_gen.sv
// Bench for reg_file_gen: four configurations driven in lockstep and checked
// against an arithmetic reference model plus directed constant expectations.
module tb_reg_file_gen;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [3:0]  rs4;
    logic [2:0]  rs3;
    logic [0:0]  rs1;
    logic [1:0]  fs;
    logic        he, hs;
    logic [15:0] i16;
    logic [7:0]  i8;
    logic [1:0]  asel, bsel;
    logic [0:0]  asel1, bsel1;
    logic [7:0]  oa0, ob0, oa1, ob1, oa3, ob3;
    logic [15:0] oa2, ob2;
    logic [3:0]  ovf0, ovf1;
    logic [0:0]  ovf2;
    logic [2:0]  ovf3;

    assign i8    = i16[7:0];
    assign asel1 = asel[0];
    assign bsel1 = bsel[0];

    int nvec = 0;
    int nerr = 0;

    // Reference state: m[instance][register], ov[instance][register].
    logic [15:0] m  [4][4];
    bit          ov [4][4];

    always #5 Clock = ~Clock;

    reg_file_gen #(.W(8), .NREG(4), .SAT(1'b0), .RESET_VAL(8'h5A)) u0 (
        .Clock(Clock), .Reset_n(Reset_n), .RegSel(rs4), .FunSel(fs), .HalfEn(he),
        .HalfSel(hs), .I(i8), .OutASel(asel), .OutBSel(bsel), .OutA(oa0),
        .OutB(ob0), .Ovf(ovf0));
    reg_file_gen #(.W(8), .NREG(4), .SAT(1'b1), .RESET_VAL(8'h00)) u1 (
        .Clock(Clock), .Reset_n(Reset_n), .RegSel(rs4), .FunSel(fs), .HalfEn(he),
        .HalfSel(hs), .I(i8), .OutASel(asel), .OutBSel(bsel), .OutA(oa1),
        .OutB(ob1), .Ovf(ovf1));
    reg_file_gen #(.W(16), .NREG(1), .SAT(1'b0), .RESET_VAL(16'h0000)) u2 (
        .Clock(Clock), .Reset_n(Reset_n), .RegSel(rs1), .FunSel(fs), .HalfEn(he),
        .HalfSel(hs), .I(i16), .OutASel(asel1), .OutBSel(bsel1), .OutA(oa2),
        .OutB(ob2), .Ovf(ovf2));
    reg_file_gen #(.W(8), .NREG(3), .SAT(1'b0), .RESET_VAL(8'h00)) u3 (
        .Clock(Clock), .Reset_n(Reset_n), .RegSel(rs3), .FunSel(fs), .HalfEn(he),
        .HalfSel(hs), .I(i8), .OutASel(asel), .OutBSel(bsel), .OutA(oa3),
        .OutB(ob3), .Ovf(ovf3));

    function automatic int wid(int n);  return (n == 2) ? 16 : 8; endfunction
    function automatic bit sat(int n);  return n == 1; endfunction
    function automatic int nrg(int n);  return (n == 2) ? 1 : (n == 3) ? 3 : 4; endfunction
    function automatic logic [15:0] rv(int n); return (n == 0) ? 16'h005A : 16'h0000; endfunction

    function automatic bit disabled(int n, int r);
        if (n == 2) return rs1[0];
        if (n == 3) return rs3[r];
        return rs4[r];
    endfunction

    function automatic logic [15:0] act_a(int n);
        case (n)
            0: return {8'h00, oa0};
            1: return {8'h00, oa1};
            2: return oa2;
            default: return {8'h00, oa3};
        endcase
    endfunction

    function automatic logic [15:0] act_b(int n);
        case (n)
            0: return {8'h00, ob0};
            1: return {8'h00, ob1};
            2: return ob2;
            default: return {8'h00, ob3};
        endcase
    endfunction

    function automatic logic [3:0] act_ovf(int n);
        case (n)
            0: return ovf0;
            1: return ovf1;
            2: return {3'b000, ovf2};
            default: return {1'b0, ovf3};
        endcase
    endfunction

    function automatic logic [15:0] exp_rd(int n, int s);
        int e;
        e = (n == 2) ? (s & 1) : s;
        return (e < nrg(n)) ? m[n][e] : 16'h0000;
    endfunction

    function automatic logic [3:0] exp_ovf(int n);
        logic [3:0] v;
        v = '0;
        for (int r = 0; r < nrg(n); r++) v[r] = ov[n][r];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++)
            for (int r = 0; r < 4; r++) begin
                m[n][r]  = rv(n);
                ov[n][r] = 1'b0;
            end
    endtask

    // Apply the current inputs to the model as one clock edge would.
    task automatic model_edge();
        for (int n = 0; n < 4; n++) begin
            for (int r = 0; r < nrg(n); r++) begin
                int unsigned q, mx, hm, iv, hw;
                q  = m[n][r];
                mx = (1 << wid(n)) - 1;
                hw = wid(n) / 2;
                hm = (1 << hw) - 1;
                iv = i16 & mx;
                ov[n][r] = 1'b0;
                if (!disabled(n, r)) begin
                    case (fs)
                        2'd0: if (q == 0) begin ov[n][r] = 1'b1; q = sat(n) ? 0 : mx; end
                              else q = q - 1;
                        2'd1: if (q == mx) begin ov[n][r] = 1'b1; q = sat(n) ? mx : 0; end
                              else q = q + 1;
                        2'd2: if (!he) q = iv;
                              else if (hs) q = (q & hm) | ((iv & hm) << hw);
                              else q = (q & ~hm) | (iv & hm);
                        default: q = 0;
                    endcase
                end
                m[n][r] = q[15:0];
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        rs4 = '0; fs = 2'd3; tick();
        fs = 2'd0; tick();
        #2 Reset_n = 1'b0;
        model_reset();
        for (int s = 0; s < 4; s++) begin
            asel = 2'(s);
            #1;
            nvec++;
            if (oa0 !== 8'h5A) begin nerr++; $display("FAIL reset_u0_outA sel%0d: got %h want 5a", s, oa0); end
            nvec++;
            if (oa1 !== 8'h00) begin nerr++; $display("FAIL reset_u1_outA sel%0d: got %h want 00", s, oa1); end
        end
        nvec++;
        if (ovf0 !== 4'h0 || ovf1 !== 4'h0) begin
            nerr++; $display("FAIL reset_ovf: got %h/%h want 0/0", ovf0, ovf1);
        end
        Reset_n = 1'b1;
        rs4 = '1;
    endtask

    task automatic test_load();
        rs4 = 4'b1011; fs = 2'd2; he = 1'b0; i16 = 16'h123C; tick();
        for (int s = 0; s < 4; s++) begin
            asel = 2'(s);
            #1;
            nvec++;
            if (oa0 !== ((s == 2) ? 8'h3C : 8'h5A)) begin
                nerr++; $display("FAIL load_r2 sel%0d: got %h want %h", s, oa0, (s == 2) ? 8'h3C : 8'h5A);
            end
        end
        rs4 = '1;
    endtask

    task automatic test_wrap_sat();
        rs4 = 4'b1110; asel = 2'd0;
        fs = 2'd2; he = 1'b0; i16 = 16'h00FF; tick();
        fs = 2'd1; tick();
        nvec++; if (oa0 !== 8'h00)  begin nerr++; $display("FAIL wrap_inc_val: got %h want 00", oa0); end
        nvec++; if (ovf0 !== 4'h1)  begin nerr++; $display("FAIL wrap_inc_ovf: got %h want 1", ovf0); end
        nvec++; if (oa1 !== 8'hFF)  begin nerr++; $display("FAIL sat_inc_val: got %h want ff", oa1); end
        nvec++; if (ovf1 !== 4'h1)  begin nerr++; $display("FAIL sat_inc_ovf: got %h want 1", ovf1); end
        tick();
        nvec++; if (oa0 !== 8'h01)  begin nerr++; $display("FAIL wrap_inc2_val: got %h want 01", oa0); end
        nvec++; if (ovf0 !== 4'h0)  begin nerr++; $display("FAIL wrap_ovf_oneshot: got %h want 0", ovf0); end
        nvec++; if (oa1 !== 8'hFF)  begin nerr++; $display("FAIL sat_inc2_val: got %h want ff", oa1); end
        nvec++; if (ovf1 !== 4'h1)  begin nerr++; $display("FAIL sat_ovf_repeat: got %h want 1", ovf1); end
        fs = 2'd3; tick();
        fs = 2'd0; tick();
        nvec++; if (oa0 !== 8'hFF)  begin nerr++; $display("FAIL wrap_dec_val: got %h want ff", oa0); end
        nvec++; if (ovf0 !== 4'h1)  begin nerr++; $display("FAIL wrap_dec_ovf: got %h want 1", ovf0); end
        nvec++; if (oa1 !== 8'h00)  begin nerr++; $display("FAIL sat_dec_val: got %h want 00", oa1); end
        nvec++; if (ovf1 !== 4'h1)  begin nerr++; $display("FAIL sat_dec_ovf: got %h want 1", ovf1); end
        rs4 = '1; tick();
        nvec++; if (ovf0 !== 4'h0 || ovf1 !== 4'h0) begin
            nerr++; $display("FAIL ovf_idle_clear: got %h/%h want 0/0", ovf0, ovf1);
        end
    endtask

    task automatic test_half();
        rs1 = 1'b0; fs = 2'd3; tick();
        fs = 2'd2; he = 1'b1; hs = 1'b1; i16 = 16'h00AB; tick();
        nvec++; if (oa2 !== 16'hAB00) begin nerr++; $display("FAIL half_high: got %h want ab00", oa2); end
        hs = 1'b0; i16 = 16'hFFCD; tick();
        nvec++; if (oa2 !== 16'hABCD) begin nerr++; $display("FAIL half_low: got %h want abcd", oa2); end
        he = 1'b0; rs1 = 1'b1;
    endtask

    task automatic test_multi();
        rs4 = '0; rs3 = '0; fs = 2'd3; tick();
        fs = 2'd1; tick(); tick();
        asel = 2'd3; bsel = 2'd3;
        #1;
        nvec++; if (oa0 !== 8'h02 || ob0 !== 8'h02) begin
            nerr++; $display("FAIL multi_dual_read: got %h/%h want 02/02", oa0, ob0);
        end
        nvec++; if (oa1 !== 8'h02 || ob1 !== 8'h02) begin
            nerr++; $display("FAIL multi_dual_read_sat: got %h/%h want 02/02", oa1, ob1);
        end
        nvec++; if (oa3 !== 8'h00) begin nerr++; $display("FAIL sel_out_of_range: got %h want 00", oa3); end
        for (int s = 0; s < 3; s++) begin
            asel = 2'(s);
            #1;
            nvec++;
            if (oa3 !== 8'h02) begin nerr++; $display("FAIL multi_nreg3 sel%0d: got %h want 02", s, oa3); end
        end
        rs4 = '1; rs3 = '1;
    endtask

    task automatic test_rbw();
        rs4 = 4'b1101; fs = 2'd2; he = 1'b0; i16 = 16'h0010; tick();
        fs = 2'd1; bsel = 2'd1;
        #1;
        nvec++; if (ob0 !== 8'h10) begin nerr++; $display("FAIL rbw_before: got %h want 10", ob0); end
        tick();
        nvec++; if (ob0 !== 8'h11) begin nerr++; $display("FAIL rbw_after: got %h want 11", ob0); end
        rs4 = '1;
    endtask

    task automatic test_reset_stream();
        rs4 = '0; fs = 2'd1; tick(); tick();
        #2 Reset_n = 1'b0;
        model_reset();
        asel = 2'd1;
        #1;
        nvec++; if (oa0 !== 8'h5A) begin nerr++; $display("FAIL stream_reset_now: got %h want 5a", oa0); end
        @(posedge Clock);
        @(posedge Clock);
        #1;
        for (int s = 0; s < 4; s++) begin
            asel = 2'(s);
            #1;
            nvec++;
            if (oa0 !== 8'h5A) begin nerr++; $display("FAIL stream_reset_hold sel%0d: got %h want 5a", s, oa0); end
        end
        Reset_n = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            asel = 2'(s);
            #1;
            nvec++;
            if (oa0 !== 8'h5B) begin nerr++; $display("FAIL stream_release sel%0d: got %h want 5b", s, oa0); end
        end
        rs4 = '1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 150; it++) begin
            rs4 = 4'($urandom);
            rs3 = 3'($urandom);
            rs1 = 1'($urandom);
            fs  = 2'($urandom);
            he  = 1'($urandom);
            hs  = 1'($urandom);
            i16 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
            for (int s = 0; s < 4; s++) begin
                asel = 2'(s);
                bsel = 2'(3 - s);
                #1;
                for (int n = 0; n < 4; n++) begin
                    nvec++;
                    if (act_a(n) !== exp_rd(n, s)) begin
                        nerr++; $display("FAIL rand_outA it%0d inst%0d sel%0d: got %h want %h", it, n, s, act_a(n), exp_rd(n, s));
                    end
                    nvec++;
                    if (act_b(n) !== exp_rd(n, 3 - s)) begin
                        nerr++; $display("FAIL rand_outB it%0d inst%0d sel%0d: got %h want %h", it, n, 3 - s, act_b(n), exp_rd(n, 3 - s));
                    end
                end
            end
            for (int n = 0; n < 4; n++) begin
                nvec++;
                if (act_ovf(n) !== exp_ovf(n)) begin
                    nerr++; $display("FAIL rand_ovf it%0d inst%0d: got %h want %h", it, n, act_ovf(n), exp_ovf(n));
                end
            end
        end
        rs4 = '1; rs3 = '1; rs1 = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        rs4 = '1; rs3 = '1; rs1 = 1'b1;
        fs = 2'd0; he = 1'b0; hs = 1'b0; i16 = '0;
        asel = '0; bsel = '0;
        model_reset();
        @(posedge Clock);
        #3 Reset_n = 1'b1;
        test_reset();
        test_load();
        test_wrap_sat();
        test_half();
        test_multi();
        test_rbw();
        test_reset_stream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/reg_file_gen.md
# reg_file_gen

Parametrised general-purpose register file: NREG registers of W bits each. Every register is built from one common counter/load cell. Each register supports decrement, increment, full load, half load, and clear, selected per cycle. The block also provides two independent combinational read ports and per-register overflow/underflow flags. It is the next-generation replacement for the fixed 4×8 register file and the address/instruction registers: one instance covers general registers (NREG=4, W=8), address registers (NREG=3), and the 16-bit instruction register (NREG=1, W=16, half load).

## Interface
- W, default 8: register width; must be even and ≥2.
- NREG, default 4: number of registers, 1..16.
- SAT, default 0: 0 = inc/dec wrap modulo 2^W; 1 = inc/dec saturate at all-ones/zero.
- RESET_VAL, default 0: W-bit value loaded into every register on reset.
- SW, derived = max(1, clog2(NREG)): select width.
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- RegSel  in  NREG  active-low per-register enable; bit k = 0 means register k executes FunSel this edge.
- FunSel  in  2  0 = decrement, 1 = increment, 2 = load, 3 = clear.
- HalfEn  in  1  only meaningful with FunSel=2: 0 = full-width load of I; 1 = half load.
- HalfSel  in  1  0 = I[W/2-1:0] into the low half; 1 = I[W/2-1:0] into the high half; the other half is kept.
- I  in  W  load data.
- OutASel, OutBSel  in  SW each  read selects.
- OutA, OutB  out  W each  selected register contents.
- Ovf  out  NREG  registered per-register wrap/saturate event flags.

## Operation
- Reset (Reset_n=0, asynchronous):
  - every register becomes RESET_VAL;
  - Ovf becomes 0;
  - OutA/OutB then show RESET_VAL for any in-range select.
- Each rising edge, every register k with RegSel[k]=0 updates per FunSel. Registers with RegSel[k]=1 hold. Multiple registers may be enabled together; all receive the same operation and data.
- Decrement:
  - SAT=0: Q−1 modulo 2^W.
  - SAT=1: when Q=0, the register holds 0.
  - Either mode: when Q=0, Ovf[k] is set.
- Increment:
  - SAT=0: Q+1 modulo 2^W.
  - SAT=1: when Q=all-ones, the register holds all-ones.
  - Either mode: when Q=all-ones, Ovf[k] is set.
- Load:
  - HalfEn=0: Q=I.
  - HalfEn=1, HalfSel=0: Q[W/2-1:0]=I[W/2-1:0].
  - HalfEn=1, HalfSel=1: Q[W-1:W/2]=I[W/2-1:0].
  - I[W-1:W/2] is ignored on half loads.
- Clear: Q=0. Clear ignores RESET_VAL.
- Ovf[k] is registered and reflects only the operation of the previous edge:
  - set for one cycle after an inc at max or dec at zero;
  - cleared on any edge where register k is disabled or performs a non-overflowing operation.
- Read ports:
  - purely combinational from current register state.
  - A read of a register written this edge returns the old value until after the edge; there is no bypass.
  - OutASel and OutBSel may be equal.
  - A select ≥ NREG drives 0.

## Timing
- Write latency: 1 edge. The new value is visible on OutA/OutB combinationally after the edge.
- Read latency: 0 cycles (combinational from Q and the select).
- Ovf: asserted in the cycle following the offending edge, for exactly one cycle per event. Repeated inc at max with SAT=1 keeps Ovf high every cycle.
- Reset_n asserted mid-operation:
  - immediate asynchronous clear of state and Ovf;
  - no edge is processed while Reset_n=0;
  - the first edge after release executes normally.
- RegSel, FunSel, HalfEn, HalfSel, and I are sampled only at the rising edge. Glitches between edges have no effect.

## Structure
- Shared package holds:
  - FunSel encodings as named constants (FS_DEC=0, FS_INC=1, FS_LOAD=2, FS_CLR=3);
  - the HalfSel encoding (HS_LOW=0, HS_HIGH=1).
- Sub-module gen_register, parameters W, SAT, RESET_VAL:
  - ports Clock, Reset_n, En (active-high), FunSel, HalfEn, HalfSel, I, Q, Ovf;
  - holds the next-state logic and the Ovf flop.
- reg_file_gen:
  - instantiates NREG copies with En=~RegSel[k];
  - contains the two read multiplexers with the out-of-range-zero rule.

## Test plan
- Reset, then FunSel value 2'b10 (load): with RESET_VAL=8'h5A, assert Reset_n=0 mid-cycle.
  - Required: OutA=8'h5A immediately and Ovf=0.
  - Then load I=8'h3C into R2 (RegSel=4'b1011): OutASel=2 shows 8'h3C after the edge; R0/R1/R3 remain 8'h5A.
- Wrap vs saturate:
  - SAT=0: R0=8'hFF, inc → 8'h00, Ovf[0]=1 for one cycle. Dec from 8'h00 → 8'hFF, Ovf[0]=1.
  - SAT=1: inc at 8'hFF holds 8'hFF with Ovf[0]=1 on consecutive cycles. Dec at 8'h00 holds 8'h00.
- Half load (W=16, NREG=1):
  - Clear, then HalfSel=1 with I=16'h00AB → 16'hAB00.
  - Then HalfSel=0 with I=16'hFFCD → 16'hABCD; the upper input byte is ignored.
- Multi-enable and dual read:
  - RegSel=4'b0000 with FunSel=clear, then inc twice → all four registers hold 8'h02.
  - OutASel=OutBSel=3 → both ports show 8'h02.
  - With NREG=3, OutASel=3 → OutA=0.
- Read-before-write:
  - R1=8'h10, inc R1 while OutBSel=1.
  - Required: OutB=8'h10 before the edge and 8'h11 after it, with no same-cycle bypass.
- Reset during streaming increments:
  - Assert Reset_n low between edges → registers return to RESET_VAL at once.
  - Held low across two edges → no change.
  - Release → the next edge increments from RESET_VAL.
